// File: rtl/tc_psum_buffer.sv
// Partial-sum buffer at the tensor-core output stage.
// Sparse (row, col, value) lanes overwrite or accumulate into an M x N array of
// DW_ACC-bit entries. The array drains one row per beat on a valid/ready stream.
// When CLR_ON_RD is set, each row is zeroed as its beat is accepted.

module tc_psum_buffer #(
    parameter int unsigned M         = 16,
    parameter int unsigned N         = 16,
    parameter int unsigned NUM_IN    = 4,
    parameter int unsigned DW_IN     = 8,
    parameter int unsigned DW_ACC    = 16,
    parameter int unsigned DW_POS    = 4,
    parameter bit          CLR_ON_RD = 1'b1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_mode,
    input  logic [DW_POS-1:0]          in_row,
    input  logic [NUM_IN*DW_POS-1:0]   in_col,
    input  logic [NUM_IN-1:0]          in_mask,
    input  logic [NUM_IN*DW_IN-1:0]    in_data,
    input  logic                       rd_start,
    output logic                       rd_busy,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DW_POS-1:0]          out_row,
    output logic                       out_last,
    output logic [N*DW_ACC-1:0]        out_data
);

    typedef enum logic [0:0] {StIdle, StDrain} state_e;

    state_e            state_q, state_d;
    logic [DW_ACC-1:0] mem_q [M][N];
    logic [DW_ACC-1:0] mem_d [M][N];
    logic [DW_POS-1:0] row_q, row_d;

    logic              wr_en;
    logic              rd_acc;
    logic              at_last;
    logic [DW_ACC-1:0] contrib [N];
    logic [N-1:0]      hit;

    // Handshake qualifiers; clr suppresses both the write and the row accept
    always_comb begin
        at_last = (row_q == DW_POS'(M - 1));
        wr_en   = in_valid && in_ready;
        rd_acc  = (state_q == StDrain) && out_ready && !clr;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rd_start && !clr) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (clr || (rd_acc && at_last)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic; out_data is forced to zero outside a drain
    always_comb begin
        in_ready  = (state_q == StIdle) && !clr;
        out_valid = (state_q == StDrain);
        rd_busy   = (state_q == StDrain);
        out_row   = row_q;
        out_last  = out_valid && at_last;
        for (int c = 0; c < int'(N); c++) begin
            out_data[c*DW_ACC +: DW_ACC] = out_valid ? mem_q[row_q][c] : '0;
        end
    end

    // Per-column sum of sign-extended lane values; colliding lanes add together
    always_comb begin
        for (int c = 0; c < int'(N); c++) begin
            contrib[c] = '0;
            hit[c]     = 1'b0;
        end
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (in_mask[i]) begin
                for (int c = 0; c < int'(N); c++) begin
                    if (int'(in_col[i*DW_POS +: DW_POS]) == c) begin
                        hit[c]     = 1'b1;
                        contrib[c] = contrib[c] + DW_ACC'($signed(in_data[i*DW_IN +: DW_IN]));
                    end
                end
            end
        end
    end

    // Buffer and drain-pointer next state; writes and accepts never coincide
    // because input is only accepted while idle
    always_comb begin
        mem_d = mem_q;
        row_d = row_q;
        if (clr) begin
            for (int r = 0; r < int'(M); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    mem_d[r][c] = '0;
                end
            end
            row_d = '0;
        end else begin
            // Out-of-range rows are accepted but discarded
            if (wr_en && (int'(in_row) < int'(M))) begin
                for (int c = 0; c < int'(N); c++) begin
                    if (hit[c]) begin
                        mem_d[in_row][c] = in_mode ? (mem_q[in_row][c] + contrib[c])
                                                   : contrib[c];
                    end
                end
            end
            if (rd_acc) begin
                if (CLR_ON_RD) begin
                    for (int c = 0; c < int'(N); c++) begin
                        mem_d[row_q][c] = '0;
                    end
                end
                row_d = at_last ? '0 : row_q + 1'b1;
            end
        end
    end

    // Buffer and drain-pointer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(M); r++) begin
                for (int c = 0; c < int'(N); c++) begin
                    mem_q[r][c] <= '0;
                end
            end
            row_q <= '0;
        end else begin
            mem_q <= mem_d;
            row_q <= row_d;
        end
    end

endmodule
